// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - valid/ready stage register with one-entry skid, flush bubble and stall counter
module pipeline_stage_reg #(
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  FLUSH_VALUE = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iFlush,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iData,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic [CNT_W-1:0]  oStallCnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              accept;
    logic              rel;

    // Both handshake outputs depend only on the state register, never on iValid/iReady.
    assign oReady    = (state_q != ST_FULL);
    assign oValid    = (state_q != ST_EMPTY);
    assign oData     = main_q;
    assign oStallCnt = cnt_q;

    assign accept = iValid & oReady;
    assign rel    = oValid & iReady;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (oValid && !iReady && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (iFlush) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VALUE;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        main_d  = iData;
                    end
                end
                ST_BUSY: begin
                    if (accept && rel) begin
                        main_d = iData;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = iData;
                    end else if (rel) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (rel) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VALUE;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VALUE;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb/tb_pipeline_stage_reg.sv - directed and random checks of pipeline_stage_reg against a queue model
module tb_pipeline_stage_reg;

    localparam int               DW = 8;
    localparam int               CW = 4;
    localparam logic [DW-1:0]    FV = 8'hE7;
    localparam logic [CW-1:0]    CNT_MAX = 4'hF;

    logic          iClk = 1'b0;
    logic          iRstN, iFlush, iValid, iReady;
    logic          oReady, oValid;
    logic [DW-1:0] iData, oData;
    logic [CW-1:0] oStallCnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data = FV;
    int            m_cnt  = 0;

    pipeline_stage_reg #(.DATA_W(DW), .FLUSH_VALUE(FV), .CNT_W(CW)) dut (
        .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
        .iData(iData), .oValid(oValid), .iReady(iReady), .oData(oData), .oStallCnt(oStallCnt)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The model treats the stage as a FIFO of at most two payloads; oData shows the head or the last shown value.
    task automatic model_edge(input logic rstn, input logic fl, input logic v, input logic [DW-1:0] d, input logic r);
        int sz;
        sz = mq.size();
        if (!rstn) begin
            mq.delete();
            m_data = FV;
            m_cnt  = 0;
        end else begin
            if (sz > 0 && !r && m_cnt < 15) m_cnt++;
            if (fl) begin
                mq.delete();
                m_data = FV;
            end else begin
                if (sz > 0 && r) void'(mq.pop_front());
                if (v && sz < 2) mq.push_back(d);
                if (mq.size() > 0) m_data = mq[0];
            end
        end
    endtask

    task automatic step(input logic rstn, input logic fl, input logic v, input logic [DW-1:0] d, input logic r);
        iRstN = rstn; iFlush = fl; iValid = v; iData = d; iReady = r;
        @(posedge iClk);
        model_edge(rstn, fl, v, d, r);
        #1;
        check("oValid",    {31'd0, oValid}, {31'd0, (mq.size() > 0)});
        check("oReady",    {31'd0, oReady}, {31'd0, (mq.size() < 2)});
        check("oData",     {24'd0, oData},  {24'd0, m_data});
        check("oStallCnt", {28'd0, oStallCnt}, m_cnt);
    endtask

    initial begin
        logic [DW-1:0] a5;
        int cnt_before;
        a5 = 8'hA5;
        iRstN = 1'b0; iFlush = 1'b0; iValid = 1'b0; iData = '0; iReady = 1'b0;

        // reset with a payload offered
        step(1'b0, 1'b0, 1'b1, a5, 1'b1);
        step(1'b0, 1'b0, 1'b1, a5, 1'b1);
        check("rst_data", {24'd0, oData}, {24'd0, FV});
        check("rst_ready", {31'd0, oReady}, 32'd1);
        step(1'b1, 1'b0, 1'b1, a5, 1'b1);
        check("first_a5", {24'd0, oData}, 32'hA5);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // back-to-back streaming
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, DW'(i), 1'b1);
            check("stream", {24'd0, oData}, i);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // backpressure into the skid
        step(1'b1, 1'b0, 1'b1, 8'h10, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
        check("skid_ready", {31'd0, oReady}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
        check("held_main", {24'd0, oData}, 32'h10);
        step(1'b1, 1'b0, 1'b1, 8'h12, 1'b1);
        check("skid_out", {24'd0, oData}, 32'h11);
        step(1'b1, 1'b0, 1'b1, 8'h12, 1'b1);
        check("third_out", {24'd0, oData}, 32'h12);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // flush while FULL with a payload offered
        step(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h21, 1'b0);
        cnt_before = m_cnt;
        step(1'b1, 1'b1, 1'b1, 8'h22, 1'b1);
        check("flush_valid", {31'd0, oValid}, 32'd0);
        check("flush_data", {24'd0, oData}, {24'd0, FV});
        check("flush_cnt", {28'd0, oStallCnt}, cnt_before);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // flush and reset each colliding with accept+release in BUSY
        step(1'b1, 1'b0, 1'b1, 8'h30, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h31, 1'b1);
        check("simul_flush", {31'd0, oValid}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h32, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        check("simul_rst", {24'd0, oData}, {24'd0, FV});

        // stall counter saturation
        step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("saturate", {28'd0, oStallCnt}, {28'd0, CNT_MAX});
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0),
                 DW'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised, flow-controlled successor to the fixed D→E pipeline register: a generic stage register carrying an opaque DATA_W-bit payload between two pipeline stages, with valid/ready handshaking, a one-entry skid buffer so that upstream ready is registered, a synchronous flush that injects a bubble of a programmable value, and a saturating stall counter. It sits between any two core stages (F/D, D/E, E/M, M/W). Callers pack their control and data fields into the payload.

## Interface
- DATA_W, 32: payload width in bits (≥1).
- FLUSH_VALUE, '0: DATA_W-bit value driven on oData after reset or flush (e.g. the NULLINS encoding).
- CNT_W, 16: stall counter width (≥1).
- iClk  in  1  clock; all state updates on posedge.
- iRstN  in  1  synchronous, active-low reset.
- iFlush  in  1  synchronous flush; empties the stage.
- iValid  in  1  upstream payload valid.
- oReady  out  1  stage can accept; registered, equals (state != FULL).
- iData  in  DATA_W  upstream payload.
- oValid  out  1  downstream payload valid; equals (state != EMPTY).
- iReady  in  1  downstream accepts.
- oData  out  DATA_W  main-entry payload.
- oStallCnt  out  CNT_W  saturating count of cycles with oValid=1 and iReady=0.

## Operation
- Accept: iValid & oReady. Release: oValid & iReady.
- Storage: main entry (drives oData) and skid entry (internal).
- States: EMPTY (no entries valid), BUSY (main valid), FULL (main and skid valid).
- EMPTY: accept → BUSY, main←iData. No accept → stay; oData holds its previous value.
- BUSY: accept & release → BUSY, main←iData. Accept & no release → FULL, skid←iData, main unchanged. Release & no accept → EMPTY. Neither → hold.
- FULL: oReady=0, so no accept. Release → BUSY, main←skid. Otherwise hold.
- Ordering is strict FIFO; no payload is dropped or duplicated except on flush.
- Flush (iFlush=1, iRstN=1): next state EMPTY, main←FLUSH_VALUE, skid discarded. Any accept or release in the same cycle is void. A payload offered in the flush cycle is lost, and upstream must treat it as flushed.
- Reset (iRstN=0) has priority over flush: state EMPTY, oData=FLUSH_VALUE, oValid=0, oReady=1, oStallCnt=0, skid cleared. Applying reset mid-transfer discards both entries.
- Stall counter: +1 on each cycle with oValid & !iReady, including in FULL. It saturates at 2^CNT_W−1 and does not wrap. It is cleared only by reset; flush does not affect it.
- Combinational paths: none from iReady or iValid to oReady. oValid and oData are direct register outputs.

## Timing
- Latency 1 cycle: a payload accepted at edge N is on oData with oValid=1 after edge N.
- Throughput is 1 payload/cycle while iReady=1. Skid depth is 1.
- When iReady falls, at most one further payload is absorbed into the skid. oReady drops in the cycle after the state becomes FULL. An upstream that samples oReady registered loses nothing.
- Recovery from FULL: oReady=1 one cycle after the first release. Skid-to-main transfer takes 1 cycle.
- Flush: oValid=0 and oData=FLUSH_VALUE in the cycle after iFlush. oReady=1 in that same cycle.
- oStallCnt updates one cycle after the counted condition.

## Test plan
- Reset: hold iRstN=0 for 2 cycles with iValid=1 and iData=0xA5 → oValid=0, oReady=1, oData=FLUSH_VALUE, oStallCnt=0. After release, the first accepted 0xA5 appears 1 cycle later.
- Streaming: iReady=1, send 0x1..0x8 back-to-back → oData=0x1..0x8 on consecutive cycles, 1-cycle latency, oReady never low.
- Backpressure/skid: stream 0x10,0x11,0x12 and drop iReady after 0x10 is shown → 0x11 held in the skid, oReady=0, 0x12 held upstream. When iReady returns, the output is 0x10,0x11,0x12 in order, with no loss or duplication. oStallCnt equals the number of stalled cycles.
- Flush in FULL with iValid=1: assert iFlush one cycle → next cycle oValid=0, oData=FLUSH_VALUE, oReady=1. Both held payloads and the offered payload are absent from the output. oStallCnt is unchanged.
- Simultaneous: in BUSY with iValid=1, iReady=1 and iFlush=1 → EMPTY; the old main is not counted as released and the new payload is discarded. Same stimulus with iRstN=0 → reset values.
- Saturation: CNT_W=4, iReady=0 with the stage valid for 20 cycles → oStallCnt stops at 15 and stays there.
